// File: rtl/mul_pkg.sv
// mul_pkg: shared types for the iterative RV32M multiplier.
package mul_pkg;
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mul_state_e;
endpackage

// File: rtl/adder.sv
// adder: WIDTH-bit adder with carry in and carry out.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    assign {cout, s} = a + b + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Works on magnitudes and negates the 2*WIDTH-bit product at the end when needed.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    mul_state_e         state, state_next;
    mul_op_e            op_q;
    logic [WIDTH-1:0]   mcand, hi, lo, sum, addend, mag_a, mag_b;
    logic [CW-1:0]      cnt;
    logic               neg, cout, a_neg, b_neg;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_neg    = a[WIDTH-1] && (mul_op_e'(op) == MULH || mul_op_e'(op) == MULHSU);
    assign b_neg    = b[WIDTH-1] && (mul_op_e'(op) == MULH);
    // The most negative value negates to itself, which is its correct unsigned magnitude
    assign mag_a    = a_neg ? -a : a;
    assign mag_b    = b_neg ? -b : b;
    assign addend   = lo[0] ? mcand : '0;
    assign prod_fix = neg ? -{hi, lo} : {hi, lo};

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    adder #(.WIDTH(WIDTH)) u_adder (
        .a   (hi),
        .b   (addend),
        .cin (1'b0),
        .s   (sum),
        .cout(cout)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = in_valid ? CALC : IDLE;
            CALC: state_next = (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
            FIX:  state_next = DONE;
            DONE: state_next = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= MUL;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: if (in_valid) begin
                    mcand <= mag_a;
                    lo    <= mag_b;
                    hi    <= '0;
                    cnt   <= '0;
                    neg   <= a_neg ^ b_neg;
                    op_q  <= mul_op_e'(op);
                end
                CALC: begin
                    {hi, lo} <= {cout, sum, lo[WIDTH-1:1]};
                    cnt      <= cnt + 1'b1;
                end
                FIX: begin
                    {hi, lo} <= prod_fix;
                    result   <= (op_q == MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
                end
                DONE: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq; directed vectors plus throttled random ops.
module tb_mul_seq;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic or_mode = 1'b0;
    logic or_val = 1'b1;
    logic [31:0] exp_q[$];

    vec_t dv[11] = '{
        '{32'h0000_0007, 32'hFFFF_FFFD, 2'b00, 32'hFFFF_FFEB},
        '{32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000},
        '{32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000},
        '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000},
        '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF},
        '{32'h0000_0007, 32'hFFFF_FFFD, 2'b01, 32'hFFFF_FFFF},
        '{32'h0000_0007, 32'hFFFF_FFFD, 2'b11, 32'h0000_0006}
    };

    mul_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
        logic [63:0] ex, ey, p;
        ex = {{32{x[31] & (o == 2'b01 || o == 2'b10)}}, x};
        ey = {{32{y[31] & (o == 2'b01)}}, y};
        p  = ex * ey;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop,
                        input logic push, input logic [31:0] e);
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout_in_ready", {31'b0, in_ready}, 32'd1);
            return;
        end
        a = va;
        b = vb;
        op = vop;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_valid(output int lat);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        fork
            forever begin
                @(posedge clk); #2;
                out_ready = or_mode ? 1'($urandom_range(0, 1)) : or_val;
            end
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk("ready_valid_exclusive", {31'b0, in_ready & out_valid}, 32'd0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                        else chk("result", result, exp_q.pop_front());
                    end
                end
            end
        join_none

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        send(dv[0].a, dv[0].b, dv[0].op, 1'b1, dv[0].e);
        wait_valid(lat);
        chk("latency", lat, 32'd33);
        for (int i = 1; i < 11; i++) send(dv[i].a, dv[i].b, dv[i].op, 1'b1, dv[i].e);
        drain();

        or_val = 1'b0;
        send(32'h1234_5678, 32'h0000_0010, 2'b00, 1'b1, 32'h2345_6780);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_result", result, 32'h2345_6780);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        or_val = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        drain();

        send(32'h0000_0009, 32'h0000_0003, 2'b00, 1'b0, 32'd0);
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_out_valid", seen, 32'd0);
        send(32'd5, 32'd6, 2'b00, 1'b1, 32'd30);
        drain();

        or_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            ra  = $urandom;
            rb  = $urandom;
            rop = 2'($urandom_range(0, 3));
            if (i % 16 == 0) ra = 32'h8000_0000;
            if (i % 16 == 1) rb = 32'hFFFF_FFFF;
            send(ra, rb, rop, 1'b1, model(ra, rb, rop));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
